// File: rtl/hps_button_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// hps_button_pkg
// Shared constants and types for the HPS push-button controller:
//   - Avalon-MM register word addresses
//   - CTRL register bit positions
//   - per-button debounce FSM state encoding
// Optional feature macro used elsewhere in this slice: HPS_BTN_AUTOREPEAT_EN
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package hps_button_pkg;

  // Register word addresses
  localparam logic [1:0] ADDR_DATA = 2'd0;  // RO debounced levels, 1 = pressed
  localparam logic [1:0] ADDR_CTRL = 2'd1;  // RW capture / autorepeat enables
  localparam logic [1:0] ADDR_MASK = 2'd2;  // RW interrupt mask
  localparam logic [1:0] ADDR_EDGE = 2'd3;  // W1C pending press bits

  // CTRL bit positions
  localparam int CTRL_CAP_EN = 0;
  localparam int CTRL_REP_EN = 1;

  // Per-button debounce state
  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_SETTLING = 1'b1
  } deb_state_t;

endpackage

// File: rtl/hps_button_ctrl_if.sv
// -----------------------------------------------------------------------------
// hps_button_ctrl_if
// Avalon-MM slave bus bundle for hps_button_ctrl, plus a debug view of the
// per-button debounce FSMs.
//
// Handshake: there is no waitrequest. A read is accepted on every rising edge
// where chipselect & read are high, and readdata is valid from the following
// rising edge (fixed latency 1) and held until the next accepted read. A write
// is accepted on every rising edge where chipselect & write are high.
//
// Signals:
//   address      [1:0]         register word address
//   chipselect                 slave select
//   read / write               strobes
//   writedata    [31:0]        write data
//   readdata     [31:0]        registered read data, zero-extended
//   dbg_settling [NUM_BTN-1:0] 1 = that button's FSM is in ST_SETTLING
// Modports: master (bus driver / bench), slave (hps_button_ctrl)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
interface hps_button_ctrl_if #(
  parameter int NUM_BTN = 4
);
  logic [1:0]         address;
  logic               chipselect;
  logic               read;
  logic               write;
  logic [31:0]        writedata;
  logic [31:0]        readdata;
  logic [NUM_BTN-1:0] dbg_settling;

  modport master (
    output address, chipselect, read, write, writedata,
    input  readdata, dbg_settling
  );

  modport slave (
    input  address, chipselect, read, write, writedata,
    output readdata, dbg_settling
  );
endinterface

// File: rtl/hps_button_ctrl_debounce.sv
// -----------------------------------------------------------------------------
// hps_button_debounce
// One button: optional polarity inversion, 2-flop synchroniser, STABLE/SETTLING
// debounce FSM with a bounded settle counter, and (with HPS_BTN_AUTOREPEAT_EN
// defined) an autorepeat counter that re-fires press while the button is held.
//
// Ports:
//   clk, reset  clock, asynchronous active-high reset
//   i_raw       raw pin (asynchronous)
//   i_rep_en    autorepeat enable (only with HPS_BTN_AUTOREPEAT_EN)
//   o_deb       debounced level, 1 = pressed
//   o_press     one-cycle pulse on accepted press (and on each repeat)
//   o_release   one-cycle pulse on accepted release
//   o_state     debounce FSM state (debug)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module hps_button_debounce
  import hps_button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,  // minimum 2
  parameter bit ACTIVE_LOW      = 1'b1
`ifdef HPS_BTN_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_raw,
`ifdef HPS_BTN_AUTOREPEAT_EN
  input  logic       i_rep_en,
`endif
  output logic       o_deb,
  output logic       o_press,
  output logic       o_release,
  output deb_state_t o_state
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             w_in;
  logic             r_sync1;
  logic             r_sync2;
  logic             r_deb;
  logic             r_press;
  logic             r_release;
  deb_state_t       r_state;
  deb_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_accept;
  logic             w_rep_pulse;

  // Normalise to 1 = pressed before synchronising so reset "released" is 0.
  assign w_in = ACTIVE_LOW ? ~i_raw : i_raw;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= w_in;
      r_sync2 <= r_sync1;
    end
  end

  // Next-state logic. The counter only runs in SETTLING and is stopped by the
  // compare against CNT_LAST, so it never wraps.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    case (r_state)
      ST_STABLE: begin
        if (r_sync2 != r_deb) begin
          w_state_nxt = ST_SETTLING;
          w_cnt_nxt   = '0;
        end
      end
      ST_SETTLING: begin
        if (r_sync2 == r_deb) begin
          w_state_nxt = ST_STABLE;          // glitch rejected, no event
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = ST_STABLE;
          w_accept    = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = ST_STABLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_STABLE;
      r_cnt     <= '0;
      r_deb     <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      if (w_accept) begin
        r_deb <= r_sync2;
      end
      r_press   <= (w_accept & r_sync2) | w_rep_pulse;
      r_release <= w_accept & ~r_sync2;
    end
  end

`ifdef HPS_BTN_AUTOREPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = (REP_MAX > 2) ? $clog2(REP_MAX) : 1;

  logic [REP_W-1:0] r_rep_cnt;
  logic             r_rep_first;  // 1 = waiting out the initial delay
  logic [REP_W-1:0] w_rep_target;

  assign w_rep_target = r_rep_first ? REP_W'(REPEAT_DELAY - 1) : REP_W'(REPEAT_PERIOD - 1);
  assign w_rep_pulse  = i_rep_en & r_deb & (r_rep_cnt == w_rep_target);

  // While released or disabled the counter is parked at 0 with the delay
  // target armed, so counting starts the cycle after the original press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rep_cnt   <= '0;
      r_rep_first <= 1'b1;
    end else if (!i_rep_en || !r_deb) begin
      r_rep_cnt   <= '0;
      r_rep_first <= 1'b1;
    end else if (w_rep_pulse) begin
      r_rep_cnt   <= '0;
      r_rep_first <= 1'b0;
    end else begin
      r_rep_cnt   <= r_rep_cnt + REP_W'(1);
    end
  end
`else
  assign w_rep_pulse = 1'b0;
`endif

  assign o_deb     = r_deb;
  assign o_press   = r_press;
  assign o_release = r_release;
  assign o_state   = r_state;

endmodule

// File: rtl/hps_button_ctrl.sv
// -----------------------------------------------------------------------------
// hps_button_ctrl
// Avalon-MM slave for the game push-buttons. Debounces NUM_BTN raw inputs,
// latches presses into a W1C edge-capture register and raises a maskable
// level interrupt.
//
// Optional feature: define HPS_BTN_AUTOREPEAT_EN to add autorepeat
// (REPEAT_DELAY / REPEAT_PERIOD parameters, CTRL bit1 becomes writable).
//
// Ports:
//   clk      system clock
//   reset    asynchronous reset, active-high
//   bus      hps_button_ctrl_if.slave (address/chipselect/read/write/
//            writedata/readdata, plus dbg_settling)
//   in_port  [NUM_BTN-1:0] raw button pins (asynchronous)
//   irq      level interrupt, |(edgecap & irqmask), registered
//
// Registers: 0 DATA (RO), 1 CTRL (RW), 2 IRQMASK (RW), 3 EDGECAP (W1C).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module hps_button_ctrl
  import hps_button_pkg::*;
#(
  parameter int NUM_BTN         = 4,       // 1..32
  parameter int DEBOUNCE_CYCLES = 500000,  // minimum 2
  parameter bit ACTIVE_LOW      = 1'b1
`ifdef HPS_BTN_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
`endif
) (
  input  logic               clk,
  input  logic               reset,
  hps_button_ctrl_if.slave   bus,
  input  logic [NUM_BTN-1:0] in_port,
  output logic               irq
);

  logic [NUM_BTN-1:0] w_deb;
  logic [NUM_BTN-1:0] w_press;
  logic [NUM_BTN-1:0] w_release_unused;
  logic [NUM_BTN-1:0] w_settling;
  deb_state_t         w_state [NUM_BTN];

  logic [31:0]        r_readdata;
  logic               r_cap_en;
  logic               r_rep_en;
  logic [NUM_BTN-1:0] r_mask;
  logic [NUM_BTN-1:0] r_edge;
  logic               r_irq;

  logic               w_wr;
  logic               w_rd;
  logic [NUM_BTN-1:0] w_edge_clr;
  logic [NUM_BTN-1:0] w_edge_set;
  logic [31:0]        w_rd_mux;
  logic               w_unused_wd;

  // ---------------------------------------------------------------------------
  // Per-button debounce
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
    hps_button_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW)
`ifdef HPS_BTN_AUTOREPEAT_EN
      ,
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
    ) u_deb (
      .clk       (clk),
      .reset     (reset),
      .i_raw     (in_port[gi]),
`ifdef HPS_BTN_AUTOREPEAT_EN
      .i_rep_en  (r_rep_en),
`endif
      .o_deb     (w_deb[gi]),
      .o_press   (w_press[gi]),
      .o_release (w_release_unused[gi]),
      .o_state   (w_state[gi])
    );
    assign w_settling[gi] = (w_state[gi] == ST_SETTLING);
  end

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  assign w_wr = bus.chipselect & bus.write;
  assign w_rd = bus.chipselect & bus.read;

  // Only the low NUM_BTN / CTRL bits of writedata carry meaning.
  assign w_unused_wd = ^bus.writedata;

  assign w_edge_clr = (w_wr && (bus.address == ADDR_EDGE)) ? bus.writedata[NUM_BTN-1:0] : '0;
  assign w_edge_set = w_press & {NUM_BTN{r_cap_en}};

  always_comb begin
    w_rd_mux = '0;
    case (bus.address)
      ADDR_DATA: w_rd_mux[NUM_BTN-1:0] = w_deb;
      ADDR_CTRL: begin
        w_rd_mux[CTRL_CAP_EN] = r_cap_en;
        w_rd_mux[CTRL_REP_EN] = r_rep_en;
      end
      ADDR_MASK: w_rd_mux[NUM_BTN-1:0] = r_mask;
      ADDR_EDGE: w_rd_mux[NUM_BTN-1:0] = r_edge;
      default:   w_rd_mux = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_readdata <= '0;
      r_cap_en   <= 1'b1;
      r_mask     <= '0;
      r_edge     <= '0;
      r_irq      <= 1'b0;
    end else begin
      if (w_rd) begin
        r_readdata <= w_rd_mux;
      end
      if (w_wr && (bus.address == ADDR_CTRL)) begin
        r_cap_en <= bus.writedata[CTRL_CAP_EN];
      end
      if (w_wr && (bus.address == ADDR_MASK)) begin
        r_mask <= bus.writedata[NUM_BTN-1:0];
      end
      // Set is OR-ed in after the clear so a coincident press survives W1C.
      r_edge <= (r_edge & ~w_edge_clr) | w_edge_set;
      r_irq  <= |(r_edge & r_mask);
    end
  end

`ifdef HPS_BTN_AUTOREPEAT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rep_en <= 1'b0;
    end else if (w_wr && (bus.address == ADDR_CTRL)) begin
      r_rep_en <= bus.writedata[CTRL_REP_EN];
    end
  end
`else
  assign r_rep_en = 1'b0;
`endif

  assign bus.readdata     = r_readdata;
  assign bus.dbg_settling = w_settling;
  assign irq              = r_irq;

endmodule

// File: tb/tb_hps_button_ctrl.sv
`timescale 1ns/1ps
module tb_hps_button_ctrl;

  localparam int NUM_BTN = 4;
  localparam int DC      = 8;
  localparam bit ACT_LOW = 1'b1;
`ifdef HPS_BTN_AUTOREPEAT_EN
  localparam int RD = 32;
  localparam int RP = 8;
  localparam logic [31:0] CTRL_WRMASK = 32'h3;
`else
  localparam logic [31:0] CTRL_WRMASK = 32'h1;
`endif

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [NUM_BTN-1:0] in_port = '1;
  logic               irq;
  int                 n_checks = 0;
  int                 n_fail = 0;

  hps_button_ctrl_if #(.NUM_BTN(NUM_BTN)) bus_if ();

  hps_button_ctrl #(
    .NUM_BTN         (NUM_BTN),
    .DEBOUNCE_CYCLES (DC),
    .ACTIVE_LOW      (ACT_LOW)
`ifdef HPS_BTN_AUTOREPEAT_EN
    ,
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
`endif
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus_if),
    .in_port (in_port),
    .irq     (irq)
  );

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model: input delay line of two samples, per-bit run length of
  // consecutive mismatching samples (DC+1 in a row flips the level), hold time
  // since acceptance for autorepeat, and the register file.
  // ---------------------------------------------------------------------------
  logic [NUM_BTN-1:0] m_dly0 = '0, m_dly1 = '0, m_deb = '0, m_press_q = '0;
  logic [NUM_BTN-1:0] m_edge = '0, m_mask = '0, m_new_deb, m_new_press, m_clr;
  logic               m_cap = 1'b1, m_rep = 1'b0, m_irq = 1'b0;
  logic [31:0]        m_rd = '0;
  int                 m_run  [NUM_BTN];
  int                 m_hold [NUM_BTN];

  always @(posedge clk) begin
    if (reset) begin
      m_dly0 = '0; m_dly1 = '0; m_deb = '0; m_press_q = '0;
      m_edge = '0; m_mask = '0; m_cap = 1'b1; m_rep = 1'b0;
      m_irq = 1'b0; m_rd = '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        m_run[i] = 0;
        m_hold[i] = 0;
      end
    end else begin
      m_new_deb   = m_deb;
      m_new_press = '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        if (m_dly1[i] != m_deb[i]) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] == DC + 1) begin
            m_new_deb[i] = m_dly1[i];
            m_run[i] = 0;
            if (m_dly1[i]) m_new_press[i] = 1'b1;
          end
        end else begin
          m_run[i] = 0;
        end
`ifdef HPS_BTN_AUTOREPEAT_EN
        if (m_deb[i] && m_rep) begin
          m_hold[i] = m_hold[i] + 1;
          if (m_hold[i] == RD || (m_hold[i] > RD && ((m_hold[i] - RD) % RP) == 0))
            m_new_press[i] = 1'b1;
        end else begin
          m_hold[i] = 0;
        end
`endif
      end
      if (bus_if.chipselect && bus_if.read) begin
        case (bus_if.address)
          2'd0: m_rd = 32'(m_deb);
          2'd1: m_rd = {30'd0, m_rep, m_cap};
          2'd2: m_rd = 32'(m_mask);
          default: m_rd = 32'(m_edge);
        endcase
      end
      m_irq = |(m_edge & m_mask);
      m_clr = (bus_if.chipselect && bus_if.write && bus_if.address == 2'd3) ?
              bus_if.writedata[NUM_BTN-1:0] : '0;
      m_edge = (m_edge & ~m_clr) | (m_press_q & {NUM_BTN{m_cap}});
      if (bus_if.chipselect && bus_if.write && bus_if.address == 2'd1) begin
        m_cap = bus_if.writedata[0];
`ifdef HPS_BTN_AUTOREPEAT_EN
        m_rep = bus_if.writedata[1];
`endif
      end
      if (bus_if.chipselect && bus_if.write && bus_if.address == 2'd2)
        m_mask = bus_if.writedata[NUM_BTN-1:0];
      m_press_q = m_new_press;
      m_deb     = m_new_deb;
      m_dly1    = m_dly0;
      m_dly0    = ACT_LOW ? ~in_port : in_port;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (called at a falling edge, return at a falling edge)
  // ---------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_idle();
    bus_if.chipselect = 1'b0;
    bus_if.read       = 1'b0;
    bus_if.write      = 1'b0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus_if.chipselect = 1'b1;
    bus_if.write      = 1'b1;
    bus_if.address    = a;
    bus_if.writedata  = d;
    @(negedge clk);
    bus_idle();
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    bus_if.chipselect = 1'b1;
    bus_if.read       = 1'b1;
    bus_if.address    = a;
    @(negedge clk);
    bus_idle();
    d = bus_if.readdata;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    logic [31:0] v;
    logic [31:0] exp_q [$];
    bus_write(2'd2, 32'hF);
    in_port[0] = 1'b0;
    tick(14);
    bus_read(2'd1, v);
    in_port[1] = 1'b0;
    tick(5);
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (bus_if.readdata !== 32'd0) begin
      n_fail++; $display("FAIL reset_readdata: got %0h expected 0", bus_if.readdata);
    end
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++; $display("FAIL reset_irq: got %0b expected 0", irq);
    end
    in_port = '1;
    @(negedge clk);
    tick(2);
    reset = 1'b0;
    tick(1);
    exp_q = '{32'h1, 32'h0, 32'h0, 32'h0};
    for (int a = 0; a < 4; a++) begin
      bus_read(2'((a + 1) % 4), v);
      n_checks++;
      if (v !== exp_q[a]) begin
        n_fail++; $display("FAIL reset_reg%0d: got %0h expected %0h", (a + 1) % 4, v, exp_q[a]);
      end
    end
    tick(15);
    bus_read(2'd0, v);
    n_checks++;
    if (v !== 32'd0) begin
      n_fail++; $display("FAIL reset_no_event_data: got %0h expected 0", v);
    end
    bus_read(2'd3, v);
    n_checks++;
    if (v !== 32'd0) begin
      n_fail++; $display("FAIL reset_no_event_edge: got %0h expected 0", v);
    end
  endtask

  task automatic test_clean_press();
    logic [31:0] v;
    bus_write(2'd2, 32'h1);
    in_port[0] = 1'b0;
    bus_if.chipselect = 1'b1;
    bus_if.read       = 1'b1;
    bus_if.address    = 2'd0;
    for (int k = 1; k <= 13; k++) begin
      tick(1);
      // readdata after edge k shows the debounced level after edge k-1
      if (k == 11) begin
        n_checks++;
        if (bus_if.readdata !== 32'h0) begin
          n_fail++; $display("FAIL press_early: got %0h expected 0 at edge 10", bus_if.readdata);
        end
      end
      if (k == 12) begin
        n_checks++;
        if (bus_if.readdata !== 32'h1) begin
          n_fail++; $display("FAIL press_latency: got %0h expected 1 at edge 11", bus_if.readdata);
        end
        n_checks++;
        if (irq !== 1'b0) begin
          n_fail++; $display("FAIL press_irq_early: got %0b expected 0", irq);
        end
      end
      if (k == 13) begin
        n_checks++;
        if (irq !== 1'b1) begin
          n_fail++; $display("FAIL press_irq: got %0b expected 1", irq);
        end
      end
    end
    bus_idle();
    bus_read(2'd3, v);
    n_checks++;
    if (v !== 32'h1) begin
      n_fail++; $display("FAIL press_edge: got %0h expected 1", v);
    end
    in_port[0] = 1'b1;
    tick(14);
    bus_write(2'd3, 32'h1);
    tick(1);
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++; $display("FAIL press_irq_clear: got %0b expected 0", irq);
    end
  endtask

  task automatic test_bounce();
    logic [31:0] v;
    for (int c = 0; c < 30; c++) begin
      in_port[1] = ((c / 3) % 2 == 0) ? 1'b0 : 1'b1;
      tick(1);
      n_checks++;
      if (irq !== 1'b0) begin
        n_fail++; $display("FAIL bounce_irq: got %0b expected 0 at cycle %0d", irq, c);
      end
    end
    in_port[1] = 1'b1;
    tick(12);
    bus_read(2'd0, v);
    n_checks++;
    if (v !== 32'h0) begin
      n_fail++; $display("FAIL bounce_data: got %0h expected 0", v);
    end
    bus_read(2'd3, v);
    n_checks++;
    if (v !== 32'h0) begin
      n_fail++; $display("FAIL bounce_edge: got %0h expected 0", v);
    end
  endtask

  task automatic test_w1c_race();
    logic [31:0] v;
    in_port[0] = 1'b0;
    tick(11);
    bus_write(2'd3, 32'h1);  // sampled on the edge that sets edgecap[0]
    bus_read(2'd3, v);
    n_checks++;
    if (v !== 32'h1) begin
      n_fail++; $display("FAIL race_set_wins: got %0h expected 1", v);
    end
    n_checks++;
    if (irq !== 1'b1) begin
      n_fail++; $display("FAIL race_irq: got %0b expected 1", irq);
    end
    bus_write(2'd3, 32'h1);
    n_checks++;
    if (irq !== 1'b1) begin
      n_fail++; $display("FAIL w1c_irq_hold: got %0b expected 1", irq);
    end
    tick(1);
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++; $display("FAIL w1c_irq_drop: got %0b expected 0", irq);
    end
    bus_read(2'd3, v);
    n_checks++;
    if (v !== 32'h0) begin
      n_fail++; $display("FAIL w1c_edge: got %0h expected 0", v);
    end
    in_port[0] = 1'b1;
    tick(14);
  endtask

  task automatic test_mask_enable();
    logic [31:0] v;
    bus_write(2'd1, 32'hFFFF_FFFF);
    bus_read(2'd1, v);
    n_checks++;
    if (v !== CTRL_WRMASK) begin
      n_fail++; $display("FAIL ctrl_upper_bits: got %0h expected %0h", v, CTRL_WRMASK);
    end
    bus_write(2'd2, 32'hFFFF_FFFF);
    bus_read(2'd2, v);
    n_checks++;
    if (v !== 32'hF) begin
      n_fail++; $display("FAIL mask_upper_bits: got %0h expected f", v);
    end
    bus_write(2'd0, 32'hF);  // DATA is read-only
    bus_write(2'd1, 32'h0);
    bus_write(2'd2, 32'h0);
    in_port[2] = 1'b0;
    tick(14);
    bus_read(2'd0, v);
    n_checks++;
    if (v !== 32'h4) begin
      n_fail++; $display("FAIL cap_off_data: got %0h expected 4", v);
    end
    bus_read(2'd3, v);
    n_checks++;
    if (v !== 32'h0) begin
      n_fail++; $display("FAIL cap_off_edge: got %0h expected 0", v);
    end
    in_port[2] = 1'b1;
    tick(14);
    bus_write(2'd1, 32'h1);
    in_port[3] = 1'b0;
    tick(14);
    bus_read(2'd3, v);
    n_checks++;
    if (v !== 32'h8) begin
      n_fail++; $display("FAIL masked_edge: got %0h expected 8", v);
    end
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++; $display("FAIL masked_irq: got %0b expected 0", irq);
    end
    bus_write(2'd2, 32'h8);
    tick(1);
    n_checks++;
    if (irq !== 1'b1) begin
      n_fail++; $display("FAIL unmasked_irq: got %0b expected 1", irq);
    end
    in_port[3] = 1'b1;
    tick(14);
    bus_write(2'd3, 32'hF);
    in_port[1:0] = 2'b00;   // simultaneous presses
    tick(14);
    bus_read(2'd3, v);
    n_checks++;
    if (v !== 32'h3) begin
      n_fail++; $display("FAIL simultaneous_edge: got %0h expected 3", v);
    end
    bus_write(2'd3, 32'h1);  // clear one bit only
    bus_read(2'd3, v);
    n_checks++;
    if (v !== 32'h2) begin
      n_fail++; $display("FAIL partial_clear: got %0h expected 2", v);
    end
    in_port[1:0] = 2'b11;
    tick(14);
    bus_write(2'd3, 32'hF);
  endtask

`ifdef HPS_BTN_AUTOREPEAT_EN
  task automatic test_autorepeat();
    int exp_off [5] = '{0, 32, 40, 48, 56};
    int k;
    int idx;
    bus_write(2'd3, 32'hF);
    bus_write(2'd2, 32'h1);
    bus_write(2'd1, 32'h3);
    in_port[0] = 1'b0;
    tick(11);               // now just after the acceptance edge
    k = 0;
    idx = 0;
    while (k <= 60) begin
      if (irq === 1'b1) begin
        n_checks++;
        if (idx >= 5 || (k - 2) !== exp_off[idx]) begin
          n_fail++;
          $display("FAIL repeat_pulse: got offset %0d expected %0d", k - 2, (idx < 5) ? exp_off[idx] : -1);
        end
        idx++;
        bus_write(2'd3, 32'h1);
        tick(1);
        k += 2;
      end else begin
        tick(1);
        k++;
      end
    end
    n_checks++;
    if (idx !== 5) begin
      n_fail++; $display("FAIL repeat_count: got %0d expected 5", idx);
    end
    in_port[0] = 1'b1;
    bus_write(2'd1, 32'h1);
    tick(14);
    bus_write(2'd3, 32'hF);
    bus_write(2'd2, 32'h0);
  endtask
`endif

  task automatic test_random();
    int hold [NUM_BTN];
    int op;
    for (int i = 0; i < NUM_BTN; i++) hold[i] = $urandom_range(1, 25);
    bus_write(2'd1, 32'h1);
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NUM_BTN; i++) begin
        if (hold[i] == 0) begin
          in_port[i] = ~in_port[i];
          hold[i] = $urandom_range(1, 25);
        end else begin
          hold[i]--;
        end
      end
      bus_idle();
      op = $urandom_range(0, 3);
      bus_if.address   = 2'($urandom_range(0, 3));
      bus_if.writedata = $urandom;
      if (op == 1) begin
        bus_if.chipselect = 1'b1; bus_if.read = 1'b1;
      end else if (op == 2) begin
        bus_if.chipselect = 1'b1; bus_if.write = 1'b1;
        if (bus_if.address == 2'd1) bus_if.writedata[0] = ($urandom_range(0, 3) != 0);
      end
      reset = (c >= 1500 && c < 1502);
      tick(1);
      n_checks++;
      if (bus_if.readdata !== m_rd) begin
        n_fail++; $display("FAIL rand_readdata: cycle %0d got %0h expected %0h", c, bus_if.readdata, m_rd);
      end
      n_checks++;
      if (irq !== m_irq) begin
        n_fail++; $display("FAIL rand_irq: cycle %0d got %0b expected %0b", c, irq, m_irq);
      end
    end
    bus_idle();
    reset = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    bus_idle();
    bus_if.address   = 2'd0;
    bus_if.writedata = 32'd0;
    tick(3);
    reset = 1'b0;
    tick(2);
    test_reset();
    test_clean_press();
    test_bounce();
    test_w1c_race();
    test_mask_enable();
`ifdef HPS_BTN_AUTOREPEAT_EN
    test_autorepeat();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
